// File: rtl/neg2048_sched.sv
// neg2048_sched: round-robin scheduler that streams a WORDS x W operand from one of two
// requesters, LSW first, optionally two's-complement negating it. Option: NEG2048_ZERO_FLAG_EN adds oZero.
module neg2048_sched #(
  parameter int W     = 32,
  parameter int WORDS = 64,
  localparam int AW   = (WORDS > 1) ? $clog2(WORDS) : 1
) (
  input  logic          iClk,
  input  logic          iRst,
  input  logic [1:0]    iReq,
  input  logic [1:0]    iSign,
  input  logic [W-1:0]  iData0,
  input  logic [W-1:0]  iData1,
  output logic [1:0]    oGnt,
  output logic [AW-1:0] oAddr,
  output logic [W-1:0]  oData,
  output logic          oValid,
  output logic [AW-1:0] oWrAddr,
  output logic          oFinish,
  output logic          oBusy
`ifdef NEG2048_ZERO_FLAG_EN
  ,
  output logic          oZero
`endif
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [AW-1:0] LastAddr = AW'(WORDS - 1);

  state_t        state_q, state_d;
  logic [1:0]    gnt_q, gnt_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [W-1:0]  data_q, data_d;
  logic          valid_q, valid_d;
  logic [AW-1:0] wrAddr_q, wrAddr_d;
  logic          finish_q, finish_d;
  logic          carry_q, carry_d;
  logic          sign_q, sign_d;
  logic          last_q, last_d;
`ifdef NEG2048_ZERO_FLAG_EN
  logic          zero_q, zero_d;
`endif

  logic [W-1:0]  word;
  logic          wordZero;
  logic          reqHeld;
  logic          pick;

  assign word     = gnt_q[1] ? iData1 : iData0;
  assign wordZero = (word == '0);
  assign reqHeld  = |(iReq & gnt_q);
  // On a tie the requester not served last wins; otherwise the lone requester.
  assign pick     = (iReq == 2'b11) ? ~last_q : iReq[1];

  // The negate carry stays 1 only while every word so far was zero, so it doubles as the zero flag.
  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    addr_d   = addr_q;
    data_d   = data_q;
    valid_d  = 1'b0;
    wrAddr_d = wrAddr_q;
    finish_d = 1'b0;
    carry_d  = carry_q;
    sign_d   = sign_q;
    last_d   = last_q;
`ifdef NEG2048_ZERO_FLAG_EN
    zero_d   = zero_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (|iReq) begin
          state_d = RUN;
          gnt_d   = pick ? 2'b10 : 2'b01;
          last_d  = pick;
          sign_d  = iSign[pick];
          addr_d  = '0;
          carry_d = 1'b1;
`ifdef NEG2048_ZERO_FLAG_EN
          zero_d  = 1'b0;
`endif
        end
      end
      RUN: begin
        data_d   = sign_q ? (~word + W'(carry_q)) : word;
        wrAddr_d = addr_q;
        valid_d  = 1'b1;
        addr_d   = addr_q + 1'b1;
        carry_d  = carry_q & wordZero;
        if (!reqHeld) begin
          state_d = IDLE;
          gnt_d   = 2'b00;
          addr_d  = '0;
        end else if (addr_q == LastAddr) begin
          state_d  = IDLE;
          gnt_d    = 2'b00;
          addr_d   = '0;
          finish_d = 1'b1;
`ifdef NEG2048_ZERO_FLAG_EN
          zero_d   = carry_q & wordZero;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      state_q  <= IDLE;
      gnt_q    <= 2'b00;
      addr_q   <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      wrAddr_q <= '0;
      finish_q <= 1'b0;
      carry_q  <= 1'b1;
      sign_q   <= 1'b0;
      last_q   <= 1'b1;
`ifdef NEG2048_ZERO_FLAG_EN
      zero_q   <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      wrAddr_q <= wrAddr_d;
      finish_q <= finish_d;
      carry_q  <= carry_d;
      sign_q   <= sign_d;
      last_q   <= last_d;
`ifdef NEG2048_ZERO_FLAG_EN
      zero_q   <= zero_d;
`endif
    end
  end

  assign oGnt    = gnt_q;
  assign oAddr   = addr_q;
  assign oData   = data_q;
  assign oValid  = valid_q;
  assign oWrAddr = wrAddr_q;
  assign oFinish = finish_q;
  assign oBusy   = (state_q == RUN);
`ifdef NEG2048_ZERO_FLAG_EN
  assign oZero   = zero_q;
`endif

endmodule

// File: tb/tb_neg2048_sched.sv
// tb_neg2048_sched: directed bench for neg2048_sched; operand buffers are modelled as arrays read at oAddr.
// Cycle N of an operation is sampled on the negedge inside it; the request is applied in cycle 0.
module tb_neg2048_sched;

  localparam int W     = 32;
  localparam int WORDS = 64;
  localparam int AW    = 6;

  logic          iClk = 1'b0;
  logic          iRst;
  logic [1:0]    iReq;
  logic [1:0]    iSign;
  logic [W-1:0]  iData0;
  logic [W-1:0]  iData1;
  logic [1:0]    oGnt;
  logic [AW-1:0] oAddr;
  logic [W-1:0]  oData;
  logic          oValid;
  logic [AW-1:0] oWrAddr;
  logic          oFinish;
  logic          oBusy;
`ifdef NEG2048_ZERO_FLAG_EN
  logic          oZero;
  logic          expZero;
`endif

  logic [W-1:0]  mem0 [WORDS];
  logic [W-1:0]  mem1 [WORDS];
  logic [W-1:0]  expWords [WORDS];
  int            vectors = 0;
  int            miscompares = 0;
  int            validCount;
  int            finishCount;

  always #5 iClk = ~iClk;

  assign iData0 = mem0[oAddr];
  assign iData1 = mem1[oAddr];

  neg2048_sched #(.W(W), .WORDS(WORDS)) dut (
    .iClk    (iClk),
    .iRst    (iRst),
    .iReq    (iReq),
    .iSign   (iSign),
    .iData0  (iData0),
    .iData1  (iData1),
    .oGnt    (oGnt),
    .oAddr   (oAddr),
    .oData   (oData),
    .oValid  (oValid),
    .oWrAddr (oWrAddr),
    .oFinish (oFinish),
    .oBusy   (oBusy)
`ifdef NEG2048_ZERO_FLAG_EN
    ,
    .oZero   (oZero)
`endif
  );

  task automatic checkOutput(input string tag, input logic [W-1:0] observed, input logic [W-1:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] req, input logic [1:0] sign);
    iReq  = req;
    iSign = sign;
  endtask

  // Called at the negedge of cycle 0 with the request applied; returns at the negedge of cycle WORDS+1.
  task automatic checkOperation(input string tag, input logic [1:0] gntExp, input logic flipSign);
    @(negedge iClk);
    checkOutput({tag, " gnt"}, W'(oGnt), W'(gntExp));
    checkOutput({tag, " busy"}, W'(oBusy), 32'd1);
    checkOutput({tag, " addr0"}, W'(oAddr), 32'd0);
    checkOutput({tag, " valid at grant"}, W'(oValid), 32'd0);
`ifdef NEG2048_ZERO_FLAG_EN
    checkOutput({tag, " zero cleared"}, W'(oZero), 32'd0);
`endif
    if (flipSign) iSign = ~iSign;
    for (int k = 0; k < WORDS; k++) begin
      @(negedge iClk);
      checkOutput($sformatf("%s w%0d valid", tag, k), W'(oValid), 32'd1);
      checkOutput($sformatf("%s w%0d wraddr", tag, k), W'(oWrAddr), W'(k));
      checkOutput($sformatf("%s w%0d data", tag, k), oData, expWords[k]);
      checkOutput($sformatf("%s w%0d finish", tag, k), W'(oFinish), W'(k == WORDS - 1));
    end
    checkOutput({tag, " gnt after"}, W'(oGnt), 32'd0);
    checkOutput({tag, " busy after"}, W'(oBusy), 32'd0);
`ifdef NEG2048_ZERO_FLAG_EN
    checkOutput({tag, " zero flag"}, W'(oZero), W'(expZero));
`endif
  endtask

  initial begin
    iRst = 1'b1;
    applyStimulus(2'b00, 2'b00);
    for (int k = 0; k < WORDS; k++) begin
      mem0[k] = 32'hA500_0000 | k;
      mem1[k] = 32'hFFFF_FFFF;
    end
    #2;
    checkOutput("reset gnt", W'(oGnt), 32'd0);
    checkOutput("reset valid", W'(oValid), 32'd0);
    checkOutput("reset data", oData, 32'd0);
    checkOutput("reset busy", W'(oBusy), 32'd0);
    checkOutput("reset finish", W'(oFinish), 32'd0);
    @(negedge iClk);
    iRst = 1'b0;
    @(negedge iClk);

    // Both requesting: first tie goes to 0, then alternate 1, 0 with one idle cycle between.
    applyStimulus(2'b11, 2'b10);
`ifdef NEG2048_ZERO_FLAG_EN
    expZero = 1'b0;
`endif
    for (int k = 0; k < WORDS; k++) expWords[k] = 32'hA500_0000 | k;
    checkOperation("rr op1", 2'b01, 1'b0);
    expWords[0] = 32'h0000_0001;
    for (int k = 1; k < WORDS; k++) expWords[k] = 32'h0;
    checkOperation("rr op2", 2'b10, 1'b0);
    for (int k = 0; k < WORDS; k++) expWords[k] = 32'hA500_0000 | k;
    checkOperation("rr op3", 2'b01, 1'b0);
    applyStimulus(2'b00, 2'b00);
    @(negedge iClk);
    checkOutput("idle valid", W'(oValid), 32'd0);
    checkOutput("idle gnt", W'(oGnt), 32'd0);

    // Negate of 1 is all ones; sign flipped mid-run must be ignored.
    for (int k = 0; k < WORDS; k++) begin
      mem0[k] = 32'h0;
      expWords[k] = 32'hFFFF_FFFF;
    end
    mem0[0] = 32'h1;
    applyStimulus(2'b01, 2'b01);
    checkOperation("neg one", 2'b01, 1'b1);
    applyStimulus(2'b00, 2'b00);
    @(negedge iClk);

    // Negate of zero is zero, with the zero flag raised.
    mem0[0] = 32'h0;
    for (int k = 0; k < WORDS; k++) expWords[k] = 32'h0;
`ifdef NEG2048_ZERO_FLAG_EN
    expZero = 1'b1;
`endif
    applyStimulus(2'b01, 2'b01);
    checkOperation("neg zero", 2'b01, 1'b0);
    applyStimulus(2'b00, 2'b00);
    @(negedge iClk);
`ifdef NEG2048_ZERO_FLAG_EN
    checkOutput("zero flag held", W'(oZero), 32'd1);
    expZero = 1'b0;
`endif

    // Carry ripples through a zero low word: 2 * 2^32 negated.
    mem0[1] = 32'h2;
    expWords[0] = 32'h0;
    expWords[1] = 32'hFFFF_FFFE;
    for (int k = 2; k < WORDS; k++) expWords[k] = 32'hFFFF_FFFF;
    applyStimulus(2'b01, 2'b01);
    checkOperation("neg carry", 2'b01, 1'b0);
    applyStimulus(2'b00, 2'b00);
    @(negedge iClk);

    // Requester 1 withdraws in its 10th RUN cycle.
    for (int k = 0; k < WORDS; k++) mem1[k] = 32'h1000_0000 + k;
    applyStimulus(2'b10, 2'b00);
    @(negedge iClk);
    checkOutput("abort gnt", W'(oGnt), 32'd2);
    validCount = 0;
    finishCount = 0;
    for (int c = 2; c <= 20; c++) begin
      @(negedge iClk);
      if (oValid) validCount++;
      if (oFinish) finishCount++;
      if (c <= 11) checkOutput($sformatf("abort w%0d data", c - 2), oData, 32'h1000_0000 + c - 2);
      if (c == 10) iReq = 2'b00;
      if (c == 11) checkOutput("abort gnt cleared", W'(oGnt), 32'd0);
    end
    checkOutput("abort valid count", W'(validCount), 32'd10);
    checkOutput("abort finish count", W'(finishCount), 32'd0);

    // Last-served pointer moved to 1 by the aborted op, so a tie now goes to 0.
    for (int k = 0; k < WORDS; k++) begin
      mem0[k] = 32'h5A00_0000 | k;
      expWords[k] = 32'h5A00_0000 | k;
    end
    applyStimulus(2'b11, 2'b00);
    checkOperation("after abort", 2'b01, 1'b0);
    applyStimulus(2'b00, 2'b00);
    @(negedge iClk);

    // Reset while word 30 is on the output.
    applyStimulus(2'b01, 2'b00);
    @(negedge iClk);
    for (int c = 2; c <= 32; c++) @(negedge iClk);
    checkOutput("pre-reset wraddr", W'(oWrAddr), 32'd30);
    iRst = 1'b1;
    applyStimulus(2'b00, 2'b00);
    #1;
    checkOutput("midrst gnt", W'(oGnt), 32'd0);
    checkOutput("midrst addr", W'(oAddr), 32'd0);
    checkOutput("midrst data", oData, 32'd0);
    checkOutput("midrst valid", W'(oValid), 32'd0);
    checkOutput("midrst wraddr", W'(oWrAddr), 32'd0);
    checkOutput("midrst finish", W'(oFinish), 32'd0);
    checkOutput("midrst busy", W'(oBusy), 32'd0);
    @(negedge iClk);
    iRst = 1'b0;
    @(negedge iClk);
    checkOutput("post-reset valid", W'(oValid), 32'd0);
    for (int k = 0; k < WORDS; k++) expWords[k] = 32'h1000_0000 + k;
    applyStimulus(2'b10, 2'b00);
    checkOperation("after reset", 2'b10, 1'b0);
    applyStimulus(2'b00, 2'b00);
    @(negedge iClk);
    checkOutput("final valid", W'(oValid), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/neg2048_sched.md
NEG2048_SCHED -- requirements
Module: neg2048_sched

Interface
REQ-001 SHALL have parameter W, default 32, meaning data word width.
REQ-002 SHALL have parameter WORDS, default 64, meaning words per operand (64 x 32 = 2048 bits).
REQ-003 SHALL have port iClk  input  1  rising-edge clock.
REQ-004 SHALL have port iRst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port iReq  input  2  per-requester operation request, held until oFinish or withdrawn.
REQ-006 SHALL have port iSign  input  2  per-requester negate flag (1 = two's-complement negate, 0 = pass-through).
REQ-007 SHALL have ports iData0 and iData1  input  W  word read from each requester's operand buffer at oAddr, same-cycle (combinational) read.
REQ-008 SHALL have port oGnt  output  2  one-hot grant, registered.
REQ-009 SHALL have port oAddr  output  log2(WORDS)  word index being read, LSW first, registered.
REQ-010 SHALL have port oData  output  W  result word, registered.
REQ-011 SHALL have port oValid  output  1  oData/oWrAddr valid this cycle.
REQ-012 SHALL have port oWrAddr  output  log2(WORDS)  index of the word on oData.
REQ-013 SHALL have port oFinish  output  1  one-cycle pulse with the last result word.
REQ-014 SHALL have port oBusy  output  1  high while the FSM is in RUN.

Function
REQ-015 SHALL implement an FSM with states IDLE and RUN.
REQ-016 IDLE: if any iReq is high, SHALL grant one requester via round-robin. Priority goes to the requester not served last. The FSM SHALL enter RUN next cycle with oGnt one-hot, oAddr=0, and carry=1.
REQ-017 SHALL latch iSign of the granted requester at grant; iSign changes during RUN SHALL be ignored.
REQ-018 RUN: each cycle SHALL read word d = iData of granted requester at oAddr, then register the following on the next edge:
- oData = sign ? (~d + carry) mod 2^W : d
- oWrAddr = oAddr
- oValid = 1
- oAddr increments.
REQ-019 SHALL update carry' = carry AND (d == 0) each RUN cycle; this yields a correct multi-word negate, including all-zero operand -> all-zero result.
REQ-020 Latency: request sampled at cycle 0 -> oGnt at 1 -> oValid cycles 2..WORDS+1. oFinish SHALL coincide with oValid for word WORDS-1.
REQ-021 After reading word WORDS-1, SHALL return to IDLE with oGnt cleared; back-to-back grant SHALL be possible on the cycle after oFinish.
REQ-022 Simultaneous requests SHALL alternate grants between 0 and 1.
REQ-023 If the granted iReq drops during RUN, SHALL abort: return to IDLE next edge, clear oGnt, no oFinish. Words already issued SHALL stand; the last-served pointer SHALL still update.
REQ-024 oValid and oFinish SHALL be 0 in every cycle not covered by REQ-018/REQ-020.

Reset
REQ-025 On iRst high, SHALL asynchronously force: state IDLE, oGnt=0, oAddr=0, oData=0, oValid=0, oWrAddr=0, oFinish=0, oBusy=0, carry=1.
REQ-026 On reset, SHALL set last-served=1 so requester 0 wins the first tie.
REQ-027 Reset mid-RUN SHALL abandon the operation with no further oValid/oFinish.

Configuration
REQ-028 With macro NEG2048_ZERO_FLAG_EN defined, SHALL add output oZero (1 bit, reset 0). oZero is registered high with oFinish iff every word read in that operation was zero, and is held until the next grant.
REQ-029 Without NEG2048_ZERO_FLAG_EN, port oZero and its logic SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-030 iReq=01, iSign[0]=1, operand0 = 1 (word0=1, rest 0) -> words 0xFFFFFFFF x64; oFinish at cycle 65.
REQ-031 iSign[0]=1, operand0 all zero -> 64 zero words; with NEG2048_ZERO_FLAG_EN, oZero=1.
REQ-032 iSign[0]=1, word0=0, word1=2, rest 0 -> word0=0, word1=0xFFFFFFFE, words 2..63 = 0xFFFFFFFF.
REQ-033 iReq=11 held through three operations -> grants in order 0, 1, 0; each operation has 64 oValid cycles; one idle cycle between operations.
REQ-034 iReq[1] drops at the 10th RUN cycle -> oGnt=00 next cycle, exactly 10 oValid, no oFinish. A subsequent request from requester 0 is granted.
REQ-035 iRst asserted mid-RUN at word 30 -> all outputs 0 immediately. After release, iReq=10 -> requester 1 granted and completes 64 words.
